i2c_bit_engine: RTL
===================

// Module: i2c_bit_engine
// PURPOSE
//   Bit-level I2C engine directly downstream of the command stage that issues cmd/write strobes.
//   Executes one bus primitive per accepted command: START, STOP, WRITE bit or READ bit.
//   Each primitive runs as four quarter-phases and drives open-drain SCL/SDA enables.
//   Supports clock stretching; reports arbitration loss and the read data bit.
// PARAMETERS
//   CLK_DIV  4  clk cycles per quarter-phase (>=2); one SCL bit = 4*CLK_DIV cycles
// PORTS
//   clk       in   1  system clock; all logic rises on posedge
//   reset     in   1  synchronous, active-low reset
//   write     in   1  command strobe; accepted only when ready=1
//   cmd       in   2  k_START_CMD=0, k_STOP_CMD=1, k_WRITE_CMD=2, k_READ_CMD=3
//   din       in   1  bit to send for k_WRITE_CMD (sampled with write)
//   scl_in    in   1  SCL pad level
//   sda_in    in   1  SDA pad level
//   scl_oe    out  1  1 = pull SCL low, 0 = release
//   sda_oe    out  1  1 = pull SDA low, 0 = release
//   ready     out  1  engine idle, can accept write
//   done      out  1  one-cycle pulse when a primitive completes
//   dout      out  1  bit sampled by the last k_READ_CMD
//   arb_lost  out  1  sticky: released SDA read back as 0 during WRITE
// BEHAVIOUR
//   Reset (reset=0 at posedge): scl_oe=0, sda_oe=0, ready=1, done=0, dout=0, arb_lost=0, state IDLE.
//   Accept: write=1 and ready=1 at posedge -> latch cmd/din, ready=0 next cycle, phase Q0, divider=0.
//   write while ready=0 is ignored. No queueing.
//   Divider counts 0..CLK_DIV-1 per quarter. Phase advances Q0->Q1->Q2->Q3 on terminal count.
//   Quarter-phase drive (scl_oe, sda_oe):
//     START: Q0 (0,0)  Q1 (0,0)  Q2 (0,1)  Q3 (1,1)
//     STOP : Q0 (1,1)  Q1 (0,1)  Q2 (0,1)  Q3 (0,0)
//     WRITE: Q0 (1,~din)  Q1 (0,~din)  Q2 (0,~din)  Q3 (1,~din)
//     READ : Q0 (1,0)  Q1 (0,0)  Q2 (0,0)  Q3 (1,0)
//   Clock stretch: in Q1 of any cmd the divider holds at 0 while scl_in=0. Counting resumes on the
//     first cycle scl_in=1. Latency = 4*CLK_DIV cycles plus stretch cycles.
//   Sampling: on the last cycle of Q2:
//     READ  -> dout <= sda_in.
//     WRITE with din=1 and sda_in=0 -> arb_lost <= 1.
//   Completion: on the last cycle of Q3, done=1 for exactly that cycle. ready=1 from the next cycle.
//     scl_oe/sda_oe hold the Q3 values until the next accept (bus stays owned after START/WRITE/READ).
//   Back-to-back: write on the first ready=1 cycle starts Q0 immediately.
//     No extra idle cycle is inserted beyond the ready cycle.
//   arb_lost clears only on reset or on an accepted k_START_CMD.
//   Reset mid-operation: outputs return to reset values on that posedge. Partial primitive abandoned.
//     No done pulse.
//   FSM: IDLE -> RUN(Q0..Q3) -> IDLE. Illegal phase/state encodings recover to IDLE.
// TESTING (CLK_DIV=4, scl_in/sda_in model pull-ups wired-AND with oe)
//   1 Reset: reset=0 for 3 cycles -> scl_oe=0, sda_oe=0, ready=1, done=0, arb_lost=0.
//   2 START accepted at t0 -> sda_oe rises at t0+9 with scl_oe=0; scl_oe=1 at t0+13;
//     done at t0+16; ready at t0+17.
//   3 WRITE din=1 with slave holding SDA low in Q2 -> arb_lost=1 after done.
//     A following START clears it.
//   4 READ with sda_in=1 -> dout=1; then READ with sda_in=0 -> dout=0; each done after 16 cycles.
//   5 Stretch: hold scl_in=0 for 10 extra cycles in Q1 -> done delayed exactly 10 cycles.
//   6 Reset at Q2 of STOP -> no done pulse; outputs at reset values next cycle.
//     write while busy is ignored (no second done).

Source files
------------

// File: rtl/i2c_bit_engine.sv
// ============================================================================
// i2c_bit_engine : bit-level I2C primitive engine (START/STOP/WRITE/READ)
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module i2c_bit_engine #(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       write,
    input  logic [1:0] cmd,
    input  logic       din,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       scl_oe,
    output logic       sda_oe,
    output logic       ready,
    output logic       done,
    output logic       dout,
    output logic       arb_lost
);

    localparam int         DIV_W       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [1:0] START_CMD   = 2'd0;
    localparam logic [1:0] STOP_CMD    = 2'd1;
    localparam logic [1:0] WRITE_CMD   = 2'd2;
    localparam logic [1:0] READ_CMD    = 2'd3;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        Q0   = 3'd1,
        Q1   = 3'd2,
        Q2   = 3'd3,
        Q3   = 3'd4
    } state_t;

    state_t           state, state_nxt;
    logic [DIV_W-1:0] div, div_nxt;
    logic [1:0]       cmd_q;
    logic             din_q;
    logic             scl_hold, sda_hold;
    logic             run_scl, run_sda;
    logic             busy, div_end, stretch, accept;

    always_comb begin
        state_nxt = state;
        div_nxt   = div;
        busy      = 1'b0;
        run_scl   = 1'b0;
        run_sda   = 1'b0;
        div_end   = (div == DIV_LAST);
        stretch   = (state == Q1) && !scl_in;
        accept    = (state == IDLE) && write;

        case (state)
            IDLE: begin
                if (write) begin
                    state_nxt = Q0;
                    div_nxt   = '0;
                end
            end
            Q0, Q1, Q2, Q3: begin
                busy = 1'b1;
                if (stretch) begin
                    div_nxt = div;
                end else if (div_end) begin
                    div_nxt = '0;
                    case (state)
                        Q0:      state_nxt = Q1;
                        Q1:      state_nxt = Q2;
                        Q2:      state_nxt = Q3;
                        default: state_nxt = IDLE;
                    endcase
                end else begin
                    div_nxt = div + DIV_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                div_nxt   = '0;
            end
        endcase

        case (cmd_q)
            START_CMD: begin
                run_scl = (state == Q3);
                run_sda = (state == Q2) || (state == Q3);
            end
            STOP_CMD: begin
                run_scl = (state == Q0);
                run_sda = (state != Q3);
            end
            WRITE_CMD: begin
                run_scl = (state == Q0) || (state == Q3);
                run_sda = ~din_q;
            end
            default: begin
                run_scl = (state == Q0) || (state == Q3);
                run_sda = 1'b0;
            end
        endcase

        // Between primitives the pads keep whatever the last Q3 drove.
        scl_oe = busy ? run_scl : scl_hold;
        sda_oe = busy ? run_sda : sda_hold;
        ready  = (state == IDLE);
        done   = (state == Q3) && div_end;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            div      <= '0;
            cmd_q    <= START_CMD;
            din_q    <= 1'b0;
            scl_hold <= 1'b0;
            sda_hold <= 1'b0;
            dout     <= 1'b0;
            arb_lost <= 1'b0;
        end else begin
            state <= state_nxt;
            div   <= div_nxt;
            if (accept) begin
                cmd_q <= cmd;
                din_q <= din;
                if (cmd == START_CMD) begin
                    arb_lost <= 1'b0;
                end
            end
            if (done) begin
                scl_hold <= run_scl;
                sda_hold <= run_sda;
            end
            if ((state == Q2) && div_end) begin
                if (cmd_q == READ_CMD) begin
                    dout <= sda_in;
                end
                if ((cmd_q == WRITE_CMD) && din_q && !sda_in) begin
                    arb_lost <= 1'b1;
                end
            end
        end
    end

endmodule

`default_nettype wire
